// File: rtl/flash_arbiter_pkg.sv
// Shared types and constants for the configuration-flash arbiter.
package flash_arb_pkg;

    // Arbiter FSM states: idle, bridge owns, internal master owns, CS-high gap
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN_BR  = 2'd1,
        OWN_INT = 2'd2,
        GAP     = 2'd3
    } arb_state_t;

    // Which master held the flash most recently (drives round-robin)
    typedef enum logic {
        OWNER_BR  = 1'b0,
        OWNER_INT = 1'b1
    } owner_t;

    // Width of the chip-select gap counter; CS_GAP must fit in it
    localparam int GAP_W = 8;

endpackage

// File: rtl/flash_arbiter_if.sv
// Bundle of the two master-side SPI ports, their req/gnt handshakes and the
// flash pins. The arbiter uses the slave view, the masters/flash the master view.
interface flash_arbiter_if;
    logic br_req;
    logic br_gnt;
    logic br_cs_n;
    logic br_sck;
    logic br_mosi;
    logic br_miso;
    logic int_req;
    logic int_gnt;
    logic int_cs_n;
    logic int_sck;
    logic int_mosi;
    logic int_miso;
    logic flash_cs_n;
    logic flash_sck;
    logic flash_mosi;
    logic flash_miso;
    logic flash_busy;

    modport slave (
        input  br_req, br_cs_n, br_sck, br_mosi,
        input  int_req, int_cs_n, int_sck, int_mosi,
        input  flash_miso,
        output br_gnt, br_miso, int_gnt, int_miso,
        output flash_cs_n, flash_sck, flash_mosi, flash_busy
    );

    modport master (
        output br_req, br_cs_n, br_sck, br_mosi,
        output int_req, int_cs_n, int_sck, int_mosi,
        output flash_miso,
        input  br_gnt, br_miso, int_gnt, int_miso,
        input  flash_cs_n, flash_sck, flash_mosi, flash_busy
    );
endinterface

// File: rtl/flash_arbiter_sync.sv
// Two-flop synchronizer for a single asynchronous level; clears to 0 on reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_sync;

    // Shift the async level through two flops to settle metastability
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

// File: rtl/flash_arbiter.sv
// Arbitrates the configuration SPI flash between the Pico bridge and the
// internal SPI master, enforcing a chip-select-high gap between owners.
module flash_arbiter #(
    parameter int CS_GAP = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    flash_arbiter_if.slave  bus
);
    import flash_arb_pkg::*;

    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(CS_GAP - 1);

    logic             w_brReqS;
    arb_state_t       r_state;
    owner_t           r_lastOwner;
    logic [GAP_W-1:0] r_gapCnt;
    logic             r_brGnt;
    logic             r_intGnt;
    logic             r_flashBusy;
    logic             w_flashCsN;
    logic             w_flashSck;
    logic             w_flashMosi;
    logic             w_brMiso;
    logic             w_intMiso;

    sync_2ff u_brReqSync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (bus.br_req),
        .o_q   (w_brReqS)
    );

    // Ownership FSM with gap counter, registered grants and registered busy flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_lastOwner <= OWNER_INT;
            r_gapCnt    <= '0;
            r_brGnt     <= 1'b0;
            r_intGnt    <= 1'b0;
            r_flashBusy <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_brReqS && (!bus.int_req || r_lastOwner == OWNER_INT)) begin
                        r_state     <= OWN_BR;
                        r_brGnt     <= 1'b1;
                        r_flashBusy <= 1'b0;
                    end else if (bus.int_req) begin
                        r_state     <= OWN_INT;
                        r_intGnt    <= 1'b1;
                        r_flashBusy <= 1'b1;
                    end else begin
                        r_flashBusy <= 1'b0;
                    end
                end
                OWN_BR: begin
                    if (!w_brReqS) begin
                        r_state     <= GAP;
                        r_gapCnt    <= GAP_LOAD;
                        r_lastOwner <= OWNER_BR;
                        r_brGnt     <= 1'b0;
                        r_flashBusy <= 1'b0;
                    end
                end
                OWN_INT: begin
                    if (!bus.int_req) begin
                        r_state     <= GAP;
                        r_gapCnt    <= GAP_LOAD;
                        r_lastOwner <= OWNER_INT;
                        r_intGnt    <= 1'b0;
                        r_flashBusy <= 1'b1;
                    end
                end
                GAP: begin
                    if (r_gapCnt == '0) begin
                        r_state     <= IDLE;
                        r_flashBusy <= bus.int_req;
                    end else begin
                        r_gapCnt    <= r_gapCnt - GAP_W'(1);
                        r_flashBusy <= (r_lastOwner == OWNER_INT);
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_brGnt     <= 1'b0;
                    r_intGnt    <= 1'b0;
                    r_flashBusy <= 1'b0;
                end
            endcase
        end
    end

    // Route the owner's SPI lines to the flash; park the pins when nobody owns it
    always_comb begin
        w_flashCsN  = 1'b1;
        w_flashSck  = 1'b0;
        w_flashMosi = 1'b0;
        w_brMiso    = 1'b0;
        w_intMiso   = 1'b0;
        case (r_state)
            OWN_BR: begin
                w_flashCsN  = bus.br_cs_n;
                w_flashSck  = bus.br_sck;
                w_flashMosi = bus.br_mosi;
                w_brMiso    = bus.flash_miso;
            end
            OWN_INT: begin
                w_flashCsN  = bus.int_cs_n;
                w_flashSck  = bus.int_sck;
                w_flashMosi = bus.int_mosi;
                w_intMiso   = bus.flash_miso;
            end
            default: begin
                w_flashCsN  = 1'b1;
            end
        endcase
    end

    assign bus.br_gnt     = r_brGnt;
    assign bus.int_gnt    = r_intGnt;
    assign bus.flash_busy = r_flashBusy;
    assign bus.flash_cs_n = w_flashCsN;
    assign bus.flash_sck  = w_flashSck;
    assign bus.flash_mosi = w_flashMosi;
    assign bus.br_miso    = w_brMiso;
    assign bus.int_miso   = w_intMiso;
endmodule

// File: doc/flash_arbiter.md
# flash_arbiter

Shares the single configuration SPI flash between two masters: the Pico pass-through SPI bridge and an internal FPGA-side SPI master. It sits between both masters and the flash pins and grants exclusive ownership through req/gnt handshakes. It enforces a minimum chip-select-high gap between owners and tells the Pico, through a busy line, when the flash is held by the FPGA.

## Interface
- CS_GAP, 4: clk cycles flash_cs_n is held high after a release before the next grant; legal range 1..255.
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous active-low reset.
- br_req  in  1  bridge request, active high (inverted pico_cs); asynchronous to clk.
- br_gnt  out  1  bridge owns the flash.
- br_cs_n, br_sck, br_mosi  in  1 each  bridge-side SPI signals.
- br_miso  out  1  flash_miso routed to the bridge.
- int_req  in  1  internal master request; clk domain.
- int_gnt  out  1  internal master owns the flash.
- int_cs_n, int_sck, int_mosi  in  1 each  internal SPI signals.
- int_miso  out  1  flash_miso routed to the internal master.
- flash_cs_n, flash_sck, flash_mosi  out  1 each  flash pins.
- flash_miso  in  1  flash data out.
- flash_busy  out  1  to a Pico GPIO; high when the bridge cannot be granted.

## Operation
- br_req passes through a 2-FF synchronizer (br_req_s). int_req is used directly.
- The FSM has four states: IDLE, OWN_BR, OWN_INT, GAP.
- **IDLE**
  - br_req_s only -> OWN_BR.
  - int_req only -> OWN_INT.
  - Both -> round-robin: the requester that was not last_owner wins. last_owner resets to INT, so the bridge wins the first tie.
- **OWN_x**: the state is held while req_x=1. When req_x=0, go to GAP, load gap_cnt=CS_GAP-1 and set last_owner=x.
- **GAP**
  - gap_cnt decrements each cycle. At 0 go to IDLE.
  - Requests arriving during GAP are not served until IDLE.
  - Arbitration in IDLE happens the same cycle, so a pending request is granted in the cycle after IDLE.
- **Grants** are registered: br_gnt = (state==OWN_BR), int_gnt = (state==OWN_INT).
- **Output mux**, selected by registered state (combinational data path):
  - OWN_BR: flash_* = br_*.
  - OWN_INT: flash_* = int_*.
  - IDLE and GAP: flash_cs_n=1, flash_sck=0, flash_mosi=0.
  - The non-owner's miso is 0. The owner's miso = flash_miso.
- A master's cs_n is ignored unless that master owns the flash. flash_cs_n is forced high in every non-OWN state.
- flash_busy is registered: 1 in OWN_INT, in GAP after an INT release, and while int_req is pending in IDLE; otherwise 0.
- A requester dropping req and re-raising it in the same GAP is served after GAP. Fairness then applies only if the other requester is waiting.
- Reset is asynchronous, mid-transfer included:
  - Immediately: state=IDLE, last_owner=INT, gap_cnt=0, synchronizer=0.
  - All outputs go to their idle values: gnts 0, flash_cs_n 1, sck 0, mosi 0, miso outs 0, flash_busy 0.

## Timing
- br_req rise to br_gnt rise: 3 clk cycles from IDLE (2 synchronizer + 1 registered grant).
- int_req rise to int_gnt rise: 1 cycle from IDLE.
- req fall to gnt fall: 1 cycle (int); 3 cycles (br).
- After gnt falls, flash_cs_n is high for exactly CS_GAP cycles of GAP plus 1 cycle in IDLE before the next grant.
- The SPI data path has no added register stage. SCK and MOSI pass combinationally, so no SPI clock-rate limit is introduced.
- Masters must hold their cs_n high until gnt is seen and must drop req only after raising cs_n.

## Structure
- Package flash_arb_pkg holds:
  - typedef enum arb_state_t {IDLE, OWN_BR, OWN_INT, GAP};
  - typedef enum owner_t {OWNER_BR, OWNER_INT};
  - localparam GAP_W = 8.
- Sub-module sync_2ff (1-bit, async active-low reset, resets to 0) for br_req. It is reusable for other Pico inputs.
- One FSM process, one gap counter, one combinational output mux.

## Test plan
- **Reset idle**: assert rst_n=0 during OWN_BR with br_sck toggling -> flash_cs_n=1, flash_sck=0, br_gnt=0, flash_busy=0 in the same cycle.
- **Bridge grant/release**: br_req 0->1 in IDLE -> br_gnt=1 on 3rd clk, flash_* follows br_* exactly. Drop br_req -> br_gnt=0 after 3 cycles, then flash_cs_n=1 for 4 GAP cycles.
- **Internal grant and busy**: int_req=1 -> int_gnt=1 next cycle, flash_busy=1. Then br_req=1 -> br_gnt stays 0 and flash_cs_n follows int_cs_n only. Release int -> br_gnt=1 after GAP+1.
- **Round-robin tie**: br_req_s and int_req rise together after reset -> bridge first. Both re-request together after GAP -> internal wins; third tie -> bridge.
- **Gap enforcement**: int_req drops and bridge is pending -> no cs_n low for CS_GAP=4 cycles. With CS_GAP=1, next grant exactly 2 cycles after gnt falls.
- **Non-owner isolation**: while bridge owns, toggle int_cs_n/int_sck/int_mosi -> no effect on flash pins, int_miso=0.
